// File: rtl/sync_debounce_edge.sv
//------------------------------------------------------------------------------
// sync_debounce_edge
//
// Brings WIDTH asynchronous inputs (buttons, switches, external strobes) into
// the CLK domain through a STAGES-deep flop chain. Each synchronized channel
// then goes through an independent debounce filter, and the block produces
// one-cycle rise/fall pulses whenever a debounced level changes.
//
// Parameters:
//   WIDTH           number of independent channels
//   STAGES          synchronizer flops per channel (>= 2)
//   DEBOUNCE_CYCLES consecutive differing samples needed to accept a change (>= 1)
//   RESET_VALUE     per-channel reset value of the chain, signal_sync and level
//
// Ports:
//   CLK          in   1      system clock, all state updates on posedge
//   nRST         in   1      synchronous active-low reset
//   signal       in   WIDTH  asynchronous raw inputs
//   signal_sync  out  WIDTH  synchronized, unfiltered inputs (last chain stage)
//   level        out  WIDTH  debounced level per channel (registered)
//   rise         out  WIDTH  one-cycle pulse on level 0->1 (registered)
//   fall         out  WIDTH  one-cycle pulse on level 1->0 (registered)
//------------------------------------------------------------------------------
module sync_debounce_edge #(
    parameter int               WIDTH           = 4,
    parameter int               STAGES          = 2,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] signal,
    output logic [WIDTH-1:0] signal_sync,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Counter wide enough to hold DEBOUNCE_CYCLES; it never needs to exceed
    // DEBOUNCE_CYCLES-1 because the change is accepted on that sample.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    // Parameter sanity checks evaluated at elaboration time.
    if (STAGES < 2) begin : g_stages_chk
        $error("sync_debounce_edge: STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_debounce_chk
        $error("sync_debounce_edge: DEBOUNCE_CYCLES must be >= 1");
    end

    //--------------------------------------------------------------------------
    // Helpers
    //--------------------------------------------------------------------------

    // True when this differing sample is the one that completes the debounce
    // window. Using >= keeps the counter from ever counting past the limit.
    function automatic logic cnt_at_limit(input logic [CNT_W-1:0] cnt);
        return (cnt >= CNT_LIMIT);
    endfunction

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    logic [STAGES-1:0][WIDTH-1:0] chain_r;
    logic [WIDTH-1:0][CNT_W-1:0]  cnt_r;
    logic [WIDTH-1:0][CNT_W-1:0]  cnt_nxt_s;
    logic [WIDTH-1:0]             level_r;
    logic [WIDTH-1:0]             level_nxt_s;
    logic [WIDTH-1:0]             change_s;
    logic [WIDTH-1:0]             rise_r;
    logic [WIDTH-1:0]             fall_r;
    logic [WIDTH-1:0]             sync_s;

    assign sync_s      = chain_r[STAGES-1];
    assign signal_sync = sync_s;
    assign level       = level_r;
    assign rise        = rise_r;
    assign fall        = fall_r;

    //--------------------------------------------------------------------------
    // Synchronizer chain
    //--------------------------------------------------------------------------

    // Shift raw inputs through STAGES flops; stage 0 is the metastability catcher.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int k = 0; k < STAGES; k++) begin
                chain_r[k] <= RESET_VALUE;
            end
        end else begin
            chain_r[0] <= signal;
            for (int k = 1; k < STAGES; k++) begin
                chain_r[k] <= chain_r[k-1];
            end
        end
    end

    //--------------------------------------------------------------------------
    // Debounce next-state
    //--------------------------------------------------------------------------

    // Per channel: an agreeing sample clears the count (this is what kills
    // glitches); DEBOUNCE_CYCLES consecutive differing samples accept the change.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_r;
        change_s    = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_s[i] == level_r[i]) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (cnt_at_limit(cnt_r[i])) begin
                cnt_nxt_s[i]   = CNT_ZERO;
                level_nxt_s[i] = sync_s[i];
                change_s[i]    = 1'b1;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
            end
        end
    end

    //--------------------------------------------------------------------------
    // Debounce and edge registers
    //--------------------------------------------------------------------------

    // Register counters, debounced level and edge pulses. Pulses are derived
    // from the same decision that updates level, so they coincide with the
    // first cycle of the new level and are exactly one cycle long.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_r   <= {WIDTH{CNT_ZERO}};
            level_r <= RESET_VALUE;
            rise_r  <= {WIDTH{1'b0}};
            fall_r  <= {WIDTH{1'b0}};
        end else begin
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            rise_r  <= change_s &  sync_s;
            fall_r  <= change_s & ~sync_s;
        end
    end

endmodule

// File: tb/tb_sync_debounce_edge.sv
//------------------------------------------------------------------------------
// Self-checking bench for sync_debounce_edge (WIDTH=4, STAGES=2,
// DEBOUNCE_CYCLES=4, RESET_VALUE=0). Directed scenarios use expectations
// written from the timing rules; the random scenario uses a window-based
// reference model of the debounce behaviour.
//------------------------------------------------------------------------------
module tb_sync_debounce_edge;

    localparam int         W   = 4;
    localparam int         ST  = 2;
    localparam int         D   = 4;
    localparam logic [3:0] RV  = 4'b0000;

    logic         CLK;
    logic         nRST;
    logic [W-1:0] signal;
    logic [W-1:0] signal_sync;
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    int n_checks = 0;
    int n_fail   = 0;

    sync_debounce_edge #(
        .WIDTH           (W),
        .STAGES          (ST),
        .DEBOUNCE_CYCLES (D),
        .RESET_VALUE     (RV)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .signal      (signal),
        .signal_sync (signal_sync),
        .level       (level),
        .rise        (rise),
        .fall        (fall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    //--------------------------------------------------------------------------
    // Reference model: a delay line for the synchronizer and, per channel, a
    // window of the most recent synchronized samples since the last accepted
    // change. The level flips when the window holds D samples that all differ.
    //--------------------------------------------------------------------------
    logic [W-1:0] m_pipe [ST];
    logic [W-1:0] m_level;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    bit           m_hist [W][$];

    task automatic model_step(input logic [W-1:0] sig, input logic rst_n);
        logic [W-1:0] sync_pre;
        bit           all_diff;
        if (!rst_n) begin
            for (int k = 0; k < ST; k++) m_pipe[k] = RV;
            m_level = RV;
            m_rise  = '0;
            m_fall  = '0;
            for (int i = 0; i < W; i++) m_hist[i].delete();
        end else begin
            sync_pre = m_pipe[ST-1];
            for (int i = 0; i < W; i++) begin
                m_hist[i].push_back(sync_pre[i]);
                if (m_hist[i].size() > D) void'(m_hist[i].pop_front());
                all_diff = (m_hist[i].size() == D);
                for (int j = 0; j < m_hist[i].size(); j++) begin
                    if (m_hist[i][j] == m_level[i]) all_diff = 1'b0;
                end
                m_rise[i] = all_diff &  sync_pre[i];
                m_fall[i] = all_diff & ~sync_pre[i];
                if (all_diff) begin
                    m_level[i] = sync_pre[i];
                    m_hist[i].delete();
                end
            end
            for (int k = ST-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = sig;
        end
    endtask

    // One clock: inputs already driven, advance model, sample outputs #1 later.
    task automatic tick();
        @(posedge CLK);
        model_step(signal, nRST);
        #1;
    endtask

    //--------------------------------------------------------------------------
    // Scenarios
    //--------------------------------------------------------------------------

    task automatic test_reset();
        nRST   = 1'b0;
        signal = 4'hF;
        for (int e = 0; e < 3; e++) begin
            tick();
            n_checks += 4;
            if (signal_sync !== 4'h0) begin n_fail++; $display("FAIL reset_sync edge %0d: got %b expected 0000", e, signal_sync); end
            if (level !== 4'h0)       begin n_fail++; $display("FAIL reset_level edge %0d: got %b expected 0000", e, level); end
            if (rise !== 4'h0)        begin n_fail++; $display("FAIL reset_rise edge %0d: got %b expected 0000", e, rise); end
            if (fall !== 4'h0)        begin n_fail++; $display("FAIL reset_fall edge %0d: got %b expected 0000", e, fall); end
        end
    endtask

    task automatic test_rise_step();
        logic [W-1:0] exp_sync, exp_level, exp_rise;
        nRST   = 1'b1;
        signal = 4'h0;
        for (int e = 0; e < 3; e++) tick();
        signal = 4'b0001;
        for (int e = 0; e < 8; e++) begin
            tick();
            exp_sync  = {3'b000, 1'(e >= 1)};
            exp_level = {3'b000, 1'(e >= 5)};
            exp_rise  = {3'b000, 1'(e == 5)};
            n_checks += 4;
            if (signal_sync !== exp_sync) begin n_fail++; $display("FAIL step_sync edge N+%0d: got %b expected %b", e, signal_sync, exp_sync); end
            if (level !== exp_level)      begin n_fail++; $display("FAIL step_level edge N+%0d: got %b expected %b", e, level, exp_level); end
            if (rise !== exp_rise)        begin n_fail++; $display("FAIL step_rise edge N+%0d: got %b expected %b", e, rise, exp_rise); end
            if (fall !== 4'b0000)         begin n_fail++; $display("FAIL step_fall edge N+%0d: got %b expected 0000", e, fall); end
        end
    endtask

    task automatic test_glitch();
        logic [W-1:0] exp_sync;
        for (int e = 0; e < 10; e++) begin
            signal = {2'b00, 1'(e < 3), 1'b1};
            tick();
            exp_sync = {2'b00, 1'(e >= 1 && e <= 3), 1'b1};
            n_checks += 4;
            if (signal_sync !== exp_sync) begin n_fail++; $display("FAIL glitch_sync edge %0d: got %b expected %b", e, signal_sync, exp_sync); end
            if (level !== 4'b0001)        begin n_fail++; $display("FAIL glitch_level edge %0d: got %b expected 0001", e, level); end
            if (rise !== 4'b0000)         begin n_fail++; $display("FAIL glitch_rise edge %0d: got %b expected 0000", e, rise); end
            if (fall !== 4'b0000)         begin n_fail++; $display("FAIL glitch_fall edge %0d: got %b expected 0000", e, fall); end
        end
    endtask

    task automatic test_swap();
        logic [W-1:0] exp_level, exp_rise, exp_fall;
        signal = 4'b1000;
        for (int e = 0; e < 6; e++) tick();
        n_checks++;
        if (level !== 4'b1000) begin n_fail++; $display("FAIL swap_setup_level: got %b expected 1000", level); end
        signal = 4'b0100;
        for (int e = 0; e < 8; e++) begin
            tick();
            exp_level = (e >= 5) ? 4'b0100 : 4'b1000;
            exp_rise  = (e == 5) ? 4'b0100 : 4'b0000;
            exp_fall  = (e == 5) ? 4'b1000 : 4'b0000;
            n_checks += 3;
            if (level !== exp_level) begin n_fail++; $display("FAIL swap_level edge %0d: got %b expected %b", e, level, exp_level); end
            if (rise !== exp_rise)   begin n_fail++; $display("FAIL swap_rise edge %0d: got %b expected %b", e, rise, exp_rise); end
            if (fall !== exp_fall)   begin n_fail++; $display("FAIL swap_fall edge %0d: got %b expected %b", e, fall, exp_fall); end
        end
    endtask

    task automatic test_reset_mid();
        int rise_cnt = 0;
        logic [W-1:0] exp_level;
        signal = 4'b0000;
        for (int e = 0; e < 7; e++) tick();
        signal = 4'b0001;
        for (int e = 0; e < 4; e++) tick();
        n_checks += 2;
        if (level !== 4'b0000)       begin n_fail++; $display("FAIL midrst_pre_level: got %b expected 0000", level); end
        if (signal_sync !== 4'b0001) begin n_fail++; $display("FAIL midrst_pre_sync: got %b expected 0001", signal_sync); end
        nRST = 1'b0;
        tick();
        n_checks += 2;
        if (signal_sync !== 4'b0000) begin n_fail++; $display("FAIL midrst_sync: got %b expected 0000", signal_sync); end
        if (level !== 4'b0000)       begin n_fail++; $display("FAIL midrst_level: got %b expected 0000", level); end
        nRST = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_level = {3'b000, 1'(e >= ST + D)};
            if (rise[0] === 1'b1) rise_cnt++;
            n_checks++;
            if (level !== exp_level) begin n_fail++; $display("FAIL midrst_level edge R+%0d: got %b expected %b", e, level, exp_level); end
        end
        n_checks++;
        if (rise_cnt !== 1) begin n_fail++; $display("FAIL midrst_rise_count: got %0d expected 1", rise_cnt); end
    endtask

    task automatic test_toggle();
        logic [5:0] seq = 6'b101101;   // seq[0] applied first: 1,0,1,1,0,1
        int rise_cnt = 0, fall_cnt = 0, rise_edge = -1;
        int exp_edge = 5 + (ST - 1) + D;  // last 0->1 applied at step 5
        for (int e = 0; e < 20; e++) begin
            signal[2] = (e < 6) ? seq[e] : 1'b1;
            tick();
            if (rise[2] === 1'b1) begin rise_cnt++; rise_edge = e; end
            if (fall[2] === 1'b1) fall_cnt++;
        end
        n_checks += 4;
        if (rise_cnt !== 1)         begin n_fail++; $display("FAIL toggle_rise_count: got %0d expected 1", rise_cnt); end
        if (rise_edge !== exp_edge) begin n_fail++; $display("FAIL toggle_rise_edge: got %0d expected %0d", rise_edge, exp_edge); end
        if (fall_cnt !== 0)         begin n_fail++; $display("FAIL toggle_fall_count: got %0d expected 0", fall_cnt); end
        if (level[2] !== 1'b1)      begin n_fail++; $display("FAIL toggle_level: got %b expected 1", level[2]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            nRST = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 7) == 0) signal[i] = ~signal[i];
            end
            tick();
            n_checks += 5;
            if (signal_sync !== m_pipe[ST-1]) begin n_fail++; $display("FAIL rand_sync cycle %0d: got %b expected %b", c, signal_sync, m_pipe[ST-1]); end
            if (level !== m_level)            begin n_fail++; $display("FAIL rand_level cycle %0d: got %b expected %b", c, level, m_level); end
            if (rise !== m_rise)              begin n_fail++; $display("FAIL rand_rise cycle %0d: got %b expected %b", c, rise, m_rise); end
            if (fall !== m_fall)              begin n_fail++; $display("FAIL rand_fall cycle %0d: got %b expected %b", c, fall, m_fall); end
            if ((rise & fall) !== 4'b0000)    begin n_fail++; $display("FAIL rand_overlap cycle %0d: got %b expected 0000", c, rise & fall); end
        end
        nRST = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < ST; k++) m_pipe[k] = RV;
        m_level = RV;
        m_rise  = '0;
        m_fall  = '0;
        nRST    = 1'b0;
        signal  = 4'h0;
        test_reset();
        test_rise_step();
        test_glitch();
        test_swap();
        test_reset_mid();
        test_toggle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
